// File: rtl/ls_queue_pkg.sv
// Shared types for the load/store queue: state encodings, label constants, entry layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ls_queue_pkg;

    // Tag value meaning "operand already valid"; never carried on the CDB.
    localparam logic [3:0] LABEL_NONE = 4'd0;

    // Values the control unit drives on isStore.
    localparam logic OP_LW = 1'b0;
    localparam logic OP_SW = 1'b1;

    typedef enum logic [1:0] {
        LS_IDLE    = 2'd0,
        LS_ACCESS  = 2'd1,
        LS_WAITCDB = 2'd2
    } ls_state_e;

    // One queue slot. Labels of LABEL_NONE mean the matching data field is valid.
    typedef struct packed {
        logic        vld;
        logic        op;
        logic [31:0] base_dat;
        logic [3:0]  base_lbl;
        logic [31:0] st_dat;
        logic [3:0]  st_lbl;
        logic [15:0] imm;
    } ls_entry_t;

    // Effective byte address: base plus sign-extended offset, 32-bit wrap.
    function automatic logic [31:0] ls_addr(input logic [31:0] base, input logic [15:0] imm);
        return base + {{16{imm[15]}}, imm};
    endfunction

    // A pending label captures a broadcast; an empty label never matches.
    function automatic logic snoop_hit(input logic [3:0] lbl, input logic bcen,
                                       input logic [3:0] bclabel);
        return bcen && (lbl != LABEL_NONE) && (lbl == bclabel);
    endfunction

endpackage

// File: rtl/ls_data_ram.sv
// Data memory for the load/store queue: 2**AW x 32 words, one shared address.
// Latency: write commits at the clock edge, read data is combinational from addr_i.
// Backpressure: none; every write strobe is accepted. rst_i clears all words synchronously.
//
// Ports: clk, rst_i (sync active-high clear), we_i/addr_i/wdat_i (write), rdat_o (async read of addr_i).
module ls_data_ram #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdat_i,
    output logic [31:0]   rdat_o
);

    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[addr_i];

endmodule

// File: rtl/ls_queue.sv
// In-order load/store buffer with data memory; snoops the CDB and broadcasts load results.
// Latency: ready lw raises require 1+MEM_LAT edges after issue; ready sw commits at edge 1+MEM_LAT.
// Backpressure: isFull (registered count only) rejects WEN; loads hold dataOut/labelOut until requireAC.
//
// Ports: clk, nRST (sync active-high reset); issue side WEN/isStore/baseData/baseLabel/storeData/
// storeLabel/immd16 with isFull and writeable_labelOut back to the CU; CDB snoop BCEN/BClabel/BCdata;
// CDB request require/requireAC with result dataOut/labelOut.
module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter logic [3:0] LABEL_BASE = 4'd12,
    parameter int         MEM_LAT    = 2,
    parameter int         MEM_AW     = 6
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        WEN,
    input  logic        isStore,
    input  logic [31:0] baseData,
    input  logic [3:0]  baseLabel,
    input  logic [31:0] storeData,
    input  logic [3:0]  storeLabel,
    input  logic [15:0] immd16,
    output logic        isFull,
    output logic [3:0]  writeable_labelOut,
    input  logic        BCEN,
    input  logic [3:0]  BClabel,
    input  logic [31:0] BCdata,
    output logic        require,
    input  logic        requireAC,
    output logic [31:0] dataOut,
    output logic [3:0]  labelOut
);

    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW       = $clog2(DEPTH + 1);
    localparam int             LW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [PW-1:0]  LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [LW-1:0]  CNT_INIT = LW'(MEM_LAT - 1);

    ls_entry_t     q_q [DEPTH];
    ls_entry_t     q_d [DEPTH];
    ls_entry_t     head_e;
    ls_entry_t     new_e;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    ls_state_e     state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    lbl_q, lbl_d;

    logic          enq;
    logic          retire;
    logic          head_rdy;
    logic          acc_done;
    logic          mem_we;
    logic [31:0]   ram_rdat;
    logic          addr_unused;

    assign head_e   = q_q[head_q];
    assign enq      = WEN && (count_q != FULL_CNT);
    assign head_rdy = head_e.vld && (head_e.base_lbl == LABEL_NONE)
                      && ((head_e.op == OP_LW) || (head_e.st_lbl == LABEL_NONE));
    assign acc_done = (state_q == LS_ACCESS) && (cnt_q == '0);
    assign mem_we   = acc_done && (head_e.op == OP_SW);
    assign retire   = mem_we || ((state_q == LS_WAITCDB) && requireAC);

    // Byte offset and bits above the memory span are discarded: addresses wrap into the array.
    assign addr_unused = ^{addr_q[31:MEM_AW+2], addr_q[1:0]};

    ls_data_ram #(.AW(MEM_AW)) u_ram (
        .clk    (clk),
        .rst_i  (nRST),
        .we_i   (mem_we),
        .addr_i (addr_q[MEM_AW+1:2]),
        .wdat_i (head_e.st_dat),
        .rdat_o (ram_rdat)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (nRST) begin
            state_q <= LS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            LS_IDLE:    if (head_rdy) state_d = LS_ACCESS;
            LS_ACCESS:  if (cnt_q == '0) state_d = (head_e.op == OP_SW) ? LS_IDLE : LS_WAITCDB;
            LS_WAITCDB: if (requireAC) state_d = LS_IDLE;
            default:    state_d = LS_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        require            = (state_q == LS_WAITCDB);
        isFull             = (count_q == FULL_CNT);
        writeable_labelOut = LABEL_BASE + 4'(tail_q);
        dataOut            = data_q;
        labelOut           = lbl_q;
    end

    // Access datapath: address latch, latency counter, load result registers.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        data_d = data_q;
        lbl_d  = lbl_q;
        if ((state_q == LS_IDLE) && head_rdy) begin
            addr_d = ls_addr(head_e.base_dat, head_e.imm);
            cnt_d  = CNT_INIT;
        end else if ((state_q == LS_ACCESS) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (acc_done && (head_e.op == OP_LW)) begin
            data_d = ram_rdat;
            lbl_d  = LABEL_BASE + 4'(head_q);
        end
    end

    // Queue contents: snoop pending labels, retire head, write new entry at tail.
    always_comb begin
        // Incoming operands matching this cycle's broadcast are taken from the CDB directly.
        new_e          = '0;
        new_e.vld      = 1'b1;
        new_e.op       = isStore;
        new_e.imm      = immd16;
        new_e.base_dat = baseData;
        new_e.base_lbl = baseLabel;
        new_e.st_dat   = storeData;
        new_e.st_lbl   = (isStore == OP_SW) ? storeLabel : LABEL_NONE;
        if (snoop_hit(new_e.base_lbl, BCEN, BClabel)) begin
            new_e.base_dat = BCdata;
            new_e.base_lbl = LABEL_NONE;
        end
        if (snoop_hit(new_e.st_lbl, BCEN, BClabel)) begin
            new_e.st_dat = BCdata;
            new_e.st_lbl = LABEL_NONE;
        end

        for (int i = 0; i < DEPTH; i++) begin
            q_d[i] = q_q[i];
            // The retiring head is skipped so its slot is clean for reuse next cycle.
            if (q_q[i].vld && !(retire && (head_q == PW'(i)))) begin
                if (snoop_hit(q_q[i].base_lbl, BCEN, BClabel)) begin
                    q_d[i].base_dat = BCdata;
                    q_d[i].base_lbl = LABEL_NONE;
                end
                if (snoop_hit(q_q[i].st_lbl, BCEN, BClabel)) begin
                    q_d[i].st_dat = BCdata;
                    q_d[i].st_lbl = LABEL_NONE;
                end
            end
        end
        if (retire) begin
            q_d[head_q].vld = 1'b0;
        end
        // enq implies not full, so tail never aliases a retiring head.
        if (enq) begin
            q_d[tail_q] = new_e;
        end
    end

    // Pointers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (retire) head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
        if (enq)    tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
        case ({enq, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            lbl_q   <= LABEL_NONE;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lbl_q   <= lbl_d;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ls_queue.sv
// Directed bench for ls_queue with a program-order memory model checked every cycle.
// Latency: n/a. Backpressure: bench drives requireAC explicitly per test.
module tb_ls_queue;

    localparam int         DEPTH      = 4;
    localparam logic [3:0] LABEL_BASE = 4'd12;
    localparam int         MEM_LAT    = 2;

    logic        clk = 1'b0;
    logic        nRST = 1'b1;
    logic        WEN = 1'b0, isStore = 1'b0, BCEN = 1'b0, requireAC = 1'b0;
    logic [31:0] baseData = '0, storeData = '0, BCdata = '0;
    logic [3:0]  baseLabel = '0, storeLabel = '0, BClabel = '0;
    logic [15:0] immd16 = '0;
    logic        isFull, require;
    logic [3:0]  writeable_labelOut, labelOut;
    logic [31:0] dataOut;

    logic        exp_acc = 1'b0;   // bench's own expectation that this WEN is accepted
    logic        req_seen = 1'b0;
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    ls_queue #(.DEPTH(DEPTH), .LABEL_BASE(LABEL_BASE), .MEM_LAT(MEM_LAT), .MEM_AW(6)) dut (
        .clk(clk), .nRST(nRST), .WEN(WEN), .isStore(isStore), .baseData(baseData),
        .baseLabel(baseLabel), .storeData(storeData), .storeLabel(storeLabel), .immd16(immd16),
        .isFull(isFull), .writeable_labelOut(writeable_labelOut), .BCEN(BCEN), .BClabel(BClabel),
        .BCdata(BCdata), .require(require), .requireAC(requireAC), .dataOut(dataOut),
        .labelOut(labelOut)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endfunction

    // ---------------- model: ops in program order, memory updated as stores retire ----------------
    typedef struct {
        bit          st;
        logic [31:0] base;
        logic [3:0]  bl;
        logic [31:0] sd;
        logic [3:0]  sl;
        logic [15:0] imm;
        logic [3:0]  tag;
    } mop_t;

    mop_t        mq[$];
    logic [31:0] mmem [64];
    int          acc_cnt = 0;

    function automatic int widx(input logic [31:0] b, input logic [15:0] i);
        logic [31:0] a;
        a = b + {{16{i[15]}}, i};
        return int'(a[7:2]);
    endfunction

    // Older stores all take effect before any younger load reaches the CDB.
    function automatic void settle_stores();
        while (mq.size() > 0 && mq[0].st) begin
            if (mq[0].bl != 4'd0 || mq[0].sl != 4'd0) chk("store_ran_early", {31'd0, require}, 32'd0);
            mmem[widx(mq[0].base, mq[0].imm)] = mq[0].sd;
            void'(mq.pop_front());
        end
    endfunction

    always @(posedge clk) begin
        mop_t m;
        if (nRST) begin
            mq.delete();
            for (int i = 0; i < 64; i++) mmem[i] = '0;
            acc_cnt = 0;
        end else begin
            if (req_seen && requireAC) begin
                settle_stores();
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (BCEN && BClabel != 4'd0) begin
                foreach (mq[i]) begin
                    if (mq[i].bl == BClabel) begin mq[i].base = BCdata; mq[i].bl = 4'd0; end
                    if (mq[i].sl == BClabel) begin mq[i].sd = BCdata; mq[i].sl = 4'd0; end
                end
            end
            if (WEN && exp_acc) begin
                m.st = isStore; m.base = baseData; m.bl = baseLabel; m.sd = storeData;
                m.sl = isStore ? storeLabel : 4'd0; m.imm = immd16;
                m.tag = LABEL_BASE + 4'(acc_cnt % DEPTH);
                if (BCEN && BClabel != 4'd0 && m.bl == BClabel) begin m.base = BCdata; m.bl = 4'd0; end
                if (BCEN && BClabel != 4'd0 && m.sl == BClabel) begin m.sd = BCdata; m.sl = 4'd0; end
                mq.push_back(m);
                acc_cnt++;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        req_seen = require;
        if (!nRST) begin
            chk("wr_label", {28'd0, writeable_labelOut}, {28'd0, LABEL_BASE + 4'(acc_cnt % DEPTH)});
            if (require) begin
                settle_stores();
                if (mq.size() == 0 || mq[0].st || mq[0].bl != 4'd0) begin
                    chk("require_without_ready_load", {31'd0, require}, 32'd0);
                end else begin
                    chk("model_label", {28'd0, labelOut}, {28'd0, mq[0].tag});
                    chk("model_data", dataOut, mmem[widx(mq[0].base, mq[0].imm)]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [3:0]  exp_lbl [4] = '{4'd13, 4'd14, 4'd15, 4'd12};
    logic [31:0] exp_dat [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA3};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        WEN = 0; BCEN = 0; requireAC = 0; exp_acc = 0;
        nRST = 1;
        step();
        nRST = 0;
    endtask

    task automatic check_reset_outs();
        chk("rst_isFull", {31'd0, isFull}, 32'd0);
        chk("rst_require", {31'd0, require}, 32'd0);
        chk("rst_dataOut", dataOut, 32'd0);
        chk("rst_labelOut", {28'd0, labelOut}, 32'd0);
        chk("rst_wr_label", {28'd0, writeable_labelOut}, 32'd12);
    endtask

    task automatic issue(input logic st, input logic [31:0] bd, input logic [3:0] bl,
                         input logic [31:0] sd, input logic [3:0] sl, input logic [15:0] imm,
                         input logic acc);
        WEN = 1; isStore = st; baseData = bd; baseLabel = bl; storeData = sd; storeLabel = sl;
        immd16 = imm; exp_acc = acc;
        step();
        WEN = 0; exp_acc = 0; baseLabel = 0; storeLabel = 0;
    endtask

    task automatic wait_req(input int budget, input string name);
        int k = 0;
        while (!require && k < budget) begin step(); k++; end
        chk(name, {31'd0, require}, 32'd1);
    endtask

    task automatic grant();
        requireAC = 1;
        step();
        requireAC = 0;
        chk("req_drop", {31'd0, require}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, bench stuck");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, then a load from an untouched word returns 0 with exact latency.
        do_reset();
        check_reset_outs();
        issue(0, 32'h1234, 0, 0, 0, 16'h0010, 1);
        chk("t1_wr_label", {28'd0, writeable_labelOut}, 32'd13);
        for (int k = 0; k < MEM_LAT; k++) begin
            step();
            chk("t1_req_early", {31'd0, require}, 32'd0);
        end
        step();
        chk("t1_req_rise", {31'd0, require}, 32'd1);
        chk("t1_label", {28'd0, labelOut}, 32'd12);
        chk("t1_data", dataOut, 32'd0);
        grant();

        // Store then load of the same word.
        do_reset();
        issue(1, 32'd0, 0, 32'hDEAD, 0, 16'd8, 1);
        issue(0, 32'd0, 0, 32'd0, 0, 16'd8, 1);
        wait_req(12, "t2_req");
        chk("t2_label", {28'd0, labelOut}, 32'd13);
        chk("t2_data", dataOut, 32'hDEAD);
        grant();

        // Load waits on base label 3, then wakes on the broadcast.
        do_reset();
        issue(1, 32'h10, 0, 32'hCAFEF00D, 0, 16'd0, 1);
        issue(0, 32'd0, 4'd3, 32'd0, 0, 16'd0, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_req_stuck", {31'd0, require}, 32'd0);
        end
        BCEN = 1; BClabel = 4'd3; BCdata = 32'h10;
        step();
        BCEN = 0; BClabel = 0;
        chk("t3_req_cdb", {31'd0, require}, 32'd0);
        for (int k = 0; k < MEM_LAT; k++) begin
            step();
            chk("t3_req_early", {31'd0, require}, 32'd0);
        end
        step();
        chk("t3_req_rise", {31'd0, require}, 32'd1);
        chk("t3_label", {28'd0, labelOut}, 32'd13);
        chk("t3_data", dataOut, 32'hCAFEF00D);
        grant();

        // Fill, reject, retire one, tag reuse.
        do_reset();
        for (int k = 0; k < 4; k++) issue(1, 32'h40, 0, 32'hA0 + 32'(k), 0, 16'(k * 4), 1);
        for (int k = 0; k < 16; k++) step();
        for (int k = 0; k < 4; k++) issue(0, 32'd0, 4'd5, 32'd0, 0, 16'(k * 4), 1);
        chk("t4_full", {31'd0, isFull}, 32'd1);
        chk("t4_full_label", {28'd0, writeable_labelOut}, 32'd12);
        issue(0, 32'h40, 0, 32'd0, 0, 16'd0, 0);
        chk("t4_still_full", {31'd0, isFull}, 32'd1);
        chk("t4_tail_kept", {28'd0, writeable_labelOut}, 32'd12);
        BCEN = 1; BClabel = 4'd5; BCdata = 32'h40;
        step();
        BCEN = 0; BClabel = 0;
        wait_req(10, "t4_req");
        chk("t4_label", {28'd0, labelOut}, 32'd12);
        chk("t4_data", dataOut, 32'hA0);
        grant();
        chk("t4_not_full", {31'd0, isFull}, 32'd0);
        chk("t4_free_tag", {28'd0, writeable_labelOut}, 32'd12);
        issue(0, 32'h40, 0, 32'd0, 0, 16'h000C, 1);
        chk("t4_reissue_label", {28'd0, writeable_labelOut}, 32'd13);
        for (int k = 0; k < 4; k++) begin
            wait_req(10, "t4_drain_req");
            chk("t4_drain_label", {28'd0, labelOut}, {28'd0, exp_lbl[k]});
            chk("t4_drain_data", dataOut, exp_dat[k]);
            grant();
        end

        // Result held stable while the CDB grant is withheld.
        issue(0, 32'h40, 0, 32'd0, 0, 16'h0004, 1);
        wait_req(10, "t5_req");
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_req_held", {31'd0, require}, 32'd1);
            chk("t5_label_held", {28'd0, labelOut}, 32'd13);
            chk("t5_data_held", dataOut, 32'hA1);
        end
        grant();

        // Reset while a store is in ACCESS: nothing commits.
        do_reset();
        issue(1, 32'd0, 0, 32'h55, 0, 16'h0030, 1);
        step();
        nRST = 1;
        step();
        nRST = 0;
        check_reset_outs();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_empty", {31'd0, require}, 32'd0);
        end
        issue(0, 32'd0, 0, 32'd0, 0, 16'h0030, 1);
        wait_req(10, "t6_req");
        chk("t6_label", {28'd0, labelOut}, 32'd12);
        chk("t6_data", dataOut, 32'd0);
        grant();

        // Issue-cycle bypass on a store base; tag 0 broadcast ignored; negative offset.
        BCEN = 1; BClabel = 4'd9; BCdata = 32'h50;
        issue(1, 32'd0, 4'd9, 32'h12345678, 0, 16'd0, 1);
        BClabel = 4'd0; BCdata = 32'hFFFF0000;
        issue(0, 32'h60, 0, 32'd0, 4'd6, 16'hFFF0, 1);
        BCEN = 0; BCdata = 0;
        wait_req(15, "t7_req");
        chk("t7_label", {28'd0, labelOut}, 32'd14);
        chk("t7_data", dataOut, 32'h12345678);
        grant();

        // Address wrap and ignored byte offset.
        issue(1, 32'h100, 0, 32'hBEEF0001, 0, 16'd8, 1);
        issue(0, 32'd0, 0, 32'd0, 0, 16'h000B, 1);
        wait_req(15, "t8_req");
        chk("t8_label", {28'd0, labelOut}, 32'd12);
        chk("t8_data", dataOut, 32'hBEEF0001);
        grant();

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
